reg_file_alu: RTL and testbench

- Datapath slice: a 16 x 8-bit register file with two combinational read ports and one synchronous write port, feeding a 2-bit-controlled ALU.
- The ALU result is the block output and is also the register-file write-back data.
- Immediates are loaded by selecting external_data_in as ALU operand B.
- Used as the execute/write-back core of the simple lab CPU datapath.

---
 rtl/reg_file_alu_pkg.sv | 14 +
 rtl/reg_file_alu_alu.sv | 25 ++
 rtl/reg_file_alu.sv | 62 ++++++
 tb/tb_reg_file_alu.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/reg_file_alu_pkg.sv
// Shared widths and the ALU operation encoding for the register-file/ALU slice.
package reg_file_alu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  typedef enum logic [1:0] {
    ALU_AND   = 2'b00,
    ALU_PASSB = 2'b01,
    ALU_ADD   = 2'b10,
    ALU_SUB   = 2'b11
  } alu_op_t;

endpackage

// File: rtl/reg_file_alu_alu.sv
// Purely combinational ALU: AND, pass-B, and modulo-2**W add/subtract.
module alu
  import reg_file_alu_pkg::*;
#(
  parameter int W = reg_file_alu_pkg::DATA_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_op_t      op,
  output logic [W-1:0] y
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    y = '0;
    unique case (op)
      ALU_AND:   y = a & b;
      ALU_PASSB: y = b;
      ALU_ADD:   y = a + b;   // carry out is dropped by the W-bit target
      ALU_SUB:   y = a - b;   // borrow wraps to 2**W - n
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/reg_file_alu.sv
// 16 x 8 register file with two combinational read ports and one write port,
// feeding an ALU whose result is both the block output and the write-back data.
module reg_file_alu
  import reg_file_alu_pkg::*;
#(
  parameter int DATA_W = reg_file_alu_pkg::DATA_W,
  parameter int ADDR_W = reg_file_alu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] external_data_in,
  input  logic              RegWrite,
  input  logic              ALUSrc,
  input  logic [1:0]        ALUControl,
  output logic [DATA_W-1:0] ALUResult
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] op_b;

  // Register 0 is never written, so after reset it reads zero forever.
  assign rd1  = regs_q[RA1];
  assign rd2  = regs_q[RA2];
  assign op_b = ALUSrc ? external_data_in : rd2;

  alu #(.W(DATA_W)) u_alu (
    .a  (rd1),
    .b  (op_b),
    .op (alu_op_t'(ALUControl)),
    .y  (ALUResult)
  );

  always_comb begin
    regs_d = regs_q;
    if (RegWrite && (WA != '0)) begin
      regs_d[WA] = ALUResult;
    end
  end

  // NOTE: this array is reset because the datapath must read all-zero registers right after reset;
  // storage with no such requirement would be left unreset so it can map onto RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: tb/tb_reg_file_alu.sv
// Self-checking bench: directed literal checks plus randomized traffic compared
// every cycle against a behavioural register-file/ALU model.
`timescale 1ns/1ps
module tb_reg_file_alu;

  logic       clk;
  logic       reset;
  logic [3:0] RA1;
  logic [3:0] RA2;
  logic [3:0] WA;
  logic [7:0] external_data_in;
  logic       RegWrite;
  logic       ALUSrc;
  logic [1:0] ALUControl;
  logic [7:0] ALUResult;

  int n_cmp = 0;
  int n_err = 0;
  bit auto_en = 0;

  int model [16];

  reg_file_alu dut (
    .clk              (clk),
    .reset            (reset),
    .RA1              (RA1),
    .RA2              (RA2),
    .WA               (WA),
    .external_data_in (external_data_in),
    .RegWrite         (RegWrite),
    .ALUSrc           (ALUSrc),
    .ALUControl       (ALUControl),
    .ALUResult        (ALUResult)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Expected result straight from the operation table, using integer arithmetic.
  function automatic int model_result();
    int a;
    int b;
    int r;
    a = model[RA1];
    b = ALUSrc ? int'(external_data_in) : model[RA2];
    case (ALUControl)
      2'd0:    r = a & b;
      2'd1:    r = b;
      2'd2:    r = (a + b) % 256;
      default: r = (a - b + 256) % 256;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state update: register 0 stays zero, reset wins over writes.
  always @(posedge clk) begin
    if (!reset && RegWrite && WA != 4'd0) begin
      model[WA] = model_result();
    end
  end

  always @(posedge reset) begin
    for (int i = 0; i < 16; i++) model[i] = 0;
  end

  always @(negedge clk) begin
    if (auto_en && !reset) begin
      check("model_cmp", ALUResult, 8'(model_result()));
    end
  end

  task automatic drive(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa,
                       input logic [7:0] ext, input logic rw, input logic src,
                       input logic [1:0] op);
    RA1 = ra1; RA2 = ra2; WA = wa; external_data_in = ext;
    RegWrite = rw; ALUSrc = src; ALUControl = op;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_imm(input logic [3:0] wa, input logic [7:0] val);
    drive(4'd0, 4'd0, wa, val, 1'b1, 1'b1, 2'b01);
    tick();
  endtask

  task automatic read_reg(input string name, input logic [3:0] addr, input logic [7:0] exp);
    drive(4'd0, addr, 4'd0, 8'h00, 1'b0, 1'b0, 2'b01);
    #1;
    check(name, ALUResult, exp);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 0;
    drive(4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0, 2'b01);
    reset = 1;
    #0.01;
    reset = 0;
    auto_en = 1;

    // Every register reads zero after reset.
    for (int i = 0; i < 16; i++) read_reg("reset_read", 4'(i), 8'h00);

    tick();
    write_imm(4'd1, 8'h00);
    write_imm(4'd2, 8'h01);
    write_imm(4'd5, 8'h05);
    write_imm(4'd4, 8'h04);
    read_reg("rd_r1", 4'd1, 8'h00);
    read_reg("rd_r2", 4'd2, 8'h01);
    read_reg("rd_r5", 4'd5, 8'h05);
    read_reg("rd_r4", 4'd4, 8'h04);

    drive(4'd5, 4'd4, 4'd0, 8'h00, 1'b0, 1'b0, 2'b10); #1; check("add_5_4", ALUResult, 8'h09);
    ALUControl = 2'b11; #1; check("sub_5_4", ALUResult, 8'h01);
    ALUControl = 2'b00; #1; check("and_5_4", ALUResult, 8'h04);
    drive(4'd4, 4'd5, 4'd0, 8'h00, 1'b0, 1'b0, 2'b11); #1; check("sub_wrap", ALUResult, 8'hFF);

    tick();
    write_imm(4'd3, 8'hFF);
    drive(4'd3, 4'd0, 4'd0, 8'h01, 1'b0, 1'b1, 2'b10); #1; check("add_wrap", ALUResult, 8'h00);

    // Writes to register 0 are discarded.
    write_imm(4'd0, 8'hAA);
    read_reg("r0_zero", 4'd0, 8'h00);

    // RegWrite low: nothing changes across several edges.
    drive(4'd0, 4'd0, 4'd6, 8'h33, 1'b0, 1'b1, 2'b01);
    repeat (3) tick();
    read_reg("r6_hold", 4'd6, 8'h00);

    // Self-write: r2 <= r2 + r2 computed from the old value.
    drive(4'd2, 4'd2, 4'd2, 8'h00, 1'b1, 1'b0, 2'b10);
    tick();
    read_reg("self_write", 4'd2, 8'h02);

    // Asynchronous reset between edges clears immediately.
    read_reg("r5_pre", 4'd5, 8'h05);
    @(posedge clk); #2;
    reset = 1;
    #1;
    check("async_clr", ALUResult, 8'h00);
    drive(4'd0, 4'd0, 4'd7, 8'h77, 1'b1, 1'b1, 2'b01);
    @(posedge clk); #1;
    RegWrite = 0;
    reset = 0;
    read_reg("rst_blocks_wr", 4'd7, 8'h00);

    // Randomized traffic, occasionally pulsing reset between edges.
    tick();
    for (int n = 0; n < 400; n++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 39) == 0) begin
        #2 reset = 1;
        #1 reset = 0;
      end
      @(posedge clk); #1;
    end

    auto_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
